// File: rtl/bp_be_loop_inference_sched.sv
// ----------------------------------------------------------------------------
// bp_be_loop_inference_sched
//
// Time-shares the single loop-inference unit among num_req_p striding-load
// detector entries. Requests are arbitrated round-robin; the winner's PC is
// latched and presented to the unit, the unit is started, optionally
// confirmed by the owner, and its remaining-iteration result is handed back
// to the owner as a one-cycle strobe.
//
// Optional feature macro: BP_BE_LOOP_INFERENCE_SCHED_TIMEOUT_EN
//   defined   - an unconfirmed discovery is abandoned after timeout_p SCOUT cycles
//   undefined - no timer; SCOUT exits only on confirm or withdraw
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   req_v_i               per-requester discovery request (level)
//   req_pc_i              per-requester striding-load PC, slice i = requester i
//   confirm_i             per-requester stride confirm (owner bit only)
//   grant_o               one-hot current owner, 0 when idle
//   start_discovery_o     one-cycle start pulse to the unit
//   confirm_discovery_o   one-cycle confirm pulse to the unit
//   striding_pc_o         latched PC of the owner
//   li_v_i, li_count_i    unit result valid / remaining-iteration count
//   li_yumi_o             unit result consumed
//   resp_v_o              one-hot one-cycle result strobe to the owner
//   resp_count_o          result value, valid with resp_v_o
// ----------------------------------------------------------------------------
module bp_be_loop_inference_sched #(
    parameter int num_req_p      = 4,
    parameter int output_range_p = 8,
    parameter int timeout_p      = 1024,
    parameter int vaddr_width_p  = 39
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_req_p-1:0]               req_v_i,
    input  logic [num_req_p*vaddr_width_p-1:0] req_pc_i,
    input  logic [num_req_p-1:0]               confirm_i,
    output logic [num_req_p-1:0]               grant_o,
    output logic                               start_discovery_o,
    output logic                               confirm_discovery_o,
    output logic [vaddr_width_p-1:0]           striding_pc_o,
    input  logic                               li_v_i,
    input  logic [output_range_p-1:0]          li_count_i,
    output logic                               li_yumi_o,
    output logic [num_req_p-1:0]               resp_v_o,
    output logic [output_range_p-1:0]          resp_count_o
);

    localparam int IdxW = $clog2(num_req_p);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SCOUT,
        S_CONFIRMED,
        S_RESP
    } state_e;

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [IdxW-1:0]           rr_q, rr_d;
    logic [vaddr_width_p-1:0]  pc_q, pc_d;
    logic [output_range_p-1:0] count_q, count_d;

    // ------------------------------------------------------------------------
    // Round-robin pick: lowest requesting index at or above rr_q, wrapping.
    // ------------------------------------------------------------------------
    logic [IdxW-1:0] pick_idx;
    logic            pick_v;

    always_comb begin
        int j;
        j        = 0;
        pick_idx = '0;
        pick_v   = 1'b0;
        for (int off = 0; off < num_req_p; off++) begin
            j = (int'(rr_q) + off) % num_req_p;
            if (!pick_v && req_v_i[j]) begin
                pick_v   = 1'b1;
                pick_idx = IdxW'(j);
            end
        end
    end

    // PC of the winning requester
    logic [vaddr_width_p-1:0] pick_pc;

    always_comb begin
        pick_pc = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (pick_idx == IdxW'(i)) begin
                pick_pc = req_pc_i[i*vaddr_width_p +: vaddr_width_p];
            end
        end
    end

    // Owner view of the per-requester inputs
    logic [num_req_p-1:0] owner_oh;
    logic                 owner_req;
    logic                 owner_conf;
    logic [IdxW-1:0]      idx_inc;

    assign owner_oh   = num_req_p'(1) << idx_q;
    assign owner_req  = req_v_i[idx_q];
    assign owner_conf = confirm_i[idx_q];
    assign idx_inc    = (idx_q == IdxW'(num_req_p - 1)) ? '0 : idx_q + 1'b1;

    // ------------------------------------------------------------------------
    // SCOUT timer
    // ------------------------------------------------------------------------
    logic timeout;

`ifdef BP_BE_LOOP_INFERENCE_SCHED_TIMEOUT_EN
    localparam int TmrW = $clog2(timeout_p + 1);

    logic [TmrW-1:0] timer_q, timer_d;

    // timer_q counts completed SCOUT cycles, so the last allowed SCOUT cycle
    // is the one where it reads timeout_p-1.
    assign timeout = (timer_q >= TmrW'(timeout_p - 1));

    always_comb begin
        timer_d = timer_q;
        if (state_q == S_START) begin
            timer_d = '0;
        end else if (state_q == S_SCOUT && timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    // No timer in this build; timeout_p is only consumed to keep it referenced.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (timeout_p > 0);
    assign timeout            = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        pc_d    = pc_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_v) begin
                    idx_d   = pick_idx;
                    pc_d    = pick_pc;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_SCOUT;
            end
            S_SCOUT: begin
                // confirm beats withdraw beats timeout; an abandoned unit is
                // simply restarted by the next start pulse.
                if (owner_conf) begin
                    state_d = S_CONFIRMED;
                end else if (!owner_req || timeout) begin
                    rr_d    = idx_inc;
                    state_d = S_IDLE;
                end
            end
            S_CONFIRMED: begin
                // Once confirmed the unit must run to completion.
                if (li_v_i) begin
                    count_d = li_count_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rr_d    = idx_inc;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        grant_o             = '0;
        start_discovery_o   = 1'b0;
        confirm_discovery_o = 1'b0;
        li_yumi_o           = 1'b0;
        resp_v_o            = '0;
        resp_count_o        = '0;
        unique case (state_q)
            S_START: begin
                grant_o           = owner_oh;
                start_discovery_o = 1'b1;
            end
            S_SCOUT: begin
                grant_o             = owner_oh;
                confirm_discovery_o = owner_conf & ~reset_i;
            end
            S_CONFIRMED: begin
                grant_o   = owner_oh;
                // A reset landing on the result cycle must not swallow it.
                li_yumi_o = li_v_i & ~reset_i;
            end
            S_RESP: begin
                grant_o      = owner_oh;
                resp_v_o     = owner_oh;
                resp_count_o = count_q;
            end
            default: begin
            end
        endcase
    end

    assign striding_pc_o = pc_q;

endmodule

// File: tb/tb_bp_be_loop_inference_sched.sv
module tb_bp_be_loop_inference_sched;

    localparam int N  = 4;
    localparam int OR = 8;
    localparam int TO = 16;
    localparam int VA = 39;

    logic            clk;
    logic            reset_i;
    logic [N-1:0]    req_v_i;
    logic [N*VA-1:0] req_pc_i;
    logic [N-1:0]    confirm_i;
    logic [N-1:0]    grant_o;
    logic            start_discovery_o;
    logic            confirm_discovery_o;
    logic [VA-1:0]   striding_pc_o;
    logic            li_v_i;
    logic [OR-1:0]   li_count_i;
    logic            li_yumi_o;
    logic [N-1:0]    resp_v_o;
    logic [OR-1:0]   resp_count_o;

    bp_be_loop_inference_sched #(
        .num_req_p     (N),
        .output_range_p(OR),
        .timeout_p     (TO),
        .vaddr_width_p (VA)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .req_v_i            (req_v_i),
        .req_pc_i           (req_pc_i),
        .confirm_i          (confirm_i),
        .grant_o            (grant_o),
        .start_discovery_o  (start_discovery_o),
        .confirm_discovery_o(confirm_discovery_o),
        .striding_pc_o      (striding_pc_o),
        .li_v_i             (li_v_i),
        .li_count_i         (li_count_i),
        .li_yumi_o          (li_yumi_o),
        .resp_v_o           (resp_v_o),
        .resp_count_o       (resp_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // reference model: round-robin pointer and the PC table
    int          rr;
    logic [VA-1:0] pcs [N];

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] o;
        o    = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    // next owner: first requester at or after rr, wrapping
    function automatic int pick(input logic [N-1:0] req, input int r);
        for (int off = 0; off < N; off++) begin
            if (req[(r + off) % N]) return (r + off) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_pcs();
        for (int i = 0; i < N; i++) begin
            pcs[i] = VA'({$urandom(), $urandom()});
            req_pc_i[i*VA +: VA] = pcs[i];
        end
    endtask

    // Full discovery from an IDLE cycle through RESP; leaves the DUT in IDLE.
    task automatic serve(input logic [N-1:0] req, input int cdly, input int ldly,
                         input logic [OR-1:0] cnt, input bit wd, output int who);
        who     = pick(req, rr);
        req_v_i = req;
        settle();
        chk("idle_grant", grant_o, 0);
        chk("idle_start", start_discovery_o, 0);
        nxt(); settle();
        chk("start_pulse", start_discovery_o, 1);
        chk("start_grant", grant_o, oh(who));
        chk("start_pc", striding_pc_o, pcs[who]);
        nxt();
        for (int k = 0; k < cdly; k++) begin
            confirm_i = ~oh(who) & N'($urandom());
            li_v_i    = 1'($urandom());
            settle();
            chk("scout_nonowner_conf", confirm_discovery_o, 0);
            chk("scout_li_ignored", li_yumi_o, 0);
            chk("scout_grant", grant_o, oh(who));
            chk("scout_no_start", start_discovery_o, 0);
            nxt();
        end
        li_v_i    = 1'b0;
        confirm_i = oh(who);
        if (wd) req_v_i[who] = 1'b0;
        settle();
        chk("confirm_pulse", confirm_discovery_o, 1);
        nxt();
        confirm_i = '0;
        for (int k = 0; k < ldly; k++) begin
            settle();
            chk("confirmed_grant", grant_o, oh(who));
            chk("confirmed_no_yumi", li_yumi_o, 0);
            chk("confirmed_no_conf", confirm_discovery_o, 0);
            nxt();
        end
        li_v_i     = 1'b1;
        li_count_i = cnt;
        settle();
        chk("yumi", li_yumi_o, 1);
        chk("no_early_resp", resp_v_o, 0);
        nxt();
        li_v_i     = 1'b0;
        li_count_i = OR'($urandom());
        settle();
        chk("resp_v", resp_v_o, oh(who));
        chk("resp_count", resp_count_o, cnt);
        chk("resp_no_yumi", li_yumi_o, 0);
        rr = (who + 1) % N;
        nxt();
    endtask

    // Owner withdraws after w SCOUT cycles; leaves the DUT in IDLE.
    task automatic abandon(input logic [N-1:0] req, input int w, output int who);
        who     = pick(req, rr);
        req_v_i = req;
        nxt(); settle();
        chk("wd_start", start_discovery_o, 1);
        chk("wd_grant", grant_o, oh(who));
        nxt();
        for (int k = 0; k < w; k++) begin
            settle();
            chk("wd_scout_grant", grant_o, oh(who));
            nxt();
        end
        req_v_i[who] = 1'b0;
        settle();
        chk("wd_no_conf", confirm_discovery_o, 0);
        nxt(); settle();
        chk("wd_idle_grant", grant_o, 0);
        chk("wd_no_resp", resp_v_o, 0);
        rr = (who + 1) % N;
    endtask

    initial begin
        int who;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        reset_i    = 1'b1;
        req_v_i    = '0;
        req_pc_i   = '0;
        confirm_i  = '0;
        li_v_i     = 1'b0;
        li_count_i = '0;
        rr         = 0;
        set_pcs();

        // ---- reset state
        nxt(); nxt(); settle();
        chk("rst_grant", grant_o, 0);
        chk("rst_start", start_discovery_o, 0);
        chk("rst_conf", confirm_discovery_o, 0);
        chk("rst_pc", striding_pc_o, 0);
        chk("rst_yumi", li_yumi_o, 0);
        chk("rst_resp_v", resp_v_o, 0);
        chk("rst_resp_cnt", resp_count_o, 0);
        reset_i = 1'b0;

        // ---- single requester, fixed PC and count
        pcs[1] = VA'(64'h8000_0040);
        req_pc_i[1*VA +: VA] = pcs[1];
        serve(4'b0010, 4, 2, 8'd17, 1'b0, who);
        chk("single_owner", who, 1);

        // ---- withdraw of owner 2, next grant to 3
        abandon(4'b1100, 3, who);
        chk("wd_owner", who, 2);
        serve(req_v_i, 1, 0, 8'h5a, 1'b0, who);
        chk("wd_next_is_3", who, 3);

        // ---- withdraw of owner 2, next grant wraps to 0
        serve(4'b0010, 0, 0, 8'h33, 1'b0, who);
        abandon(4'b0101, 2, who);
        chk("wd2_owner", who, 2);
        serve(req_v_i, 2, 1, 8'hc3, 1'b0, who);
        chk("wd_wraps_to_0", who, 0);

        // ---- confirm and withdraw in the same cycle: confirm wins
        serve(4'b0110, 2, 3, 8'h81, 1'b1, who);
        chk("conf_beats_wd", who, 1);

        // ---- SCOUT timeout
        req_v_i = 4'b0011;
        who = pick(req_v_i, rr);
        nxt(); settle();
        chk("to_start", start_discovery_o, 1);
        nxt();
`ifdef BP_BE_LOOP_INFERENCE_SCHED_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            settle();
            chk("to_scout_grant", grant_o, oh(who));
            nxt();
        end
        settle();
        chk("to_idle_grant", grant_o, 0);
        chk("to_no_resp", resp_v_o, 0);
        rr = (who + 1) % N;
        begin
            int prev;
            prev = who;
            serve(4'b0011, 1, 0, 8'h42, 1'b0, who);
            chk("to_next_requester", who, (prev + 1) % 2);
        end
`else
        for (int k = 0; k < 100; k++) begin
            settle();
            chk("no_to_scout_grant", grant_o, oh(who));
            nxt();
        end
        req_v_i[who] = 1'b0;
        nxt(); settle();
        chk("no_to_wd_idle", grant_o, 0);
        rr = (who + 1) % N;
`endif

        // ---- randomized traffic
        for (int it = 0; it < 12; it++) begin
            logic [N-1:0] rq;
            set_pcs();
            rq = N'($urandom_range(1, 15));
            serve(rq, $urandom_range(0, 5), $urandom_range(0, 3),
                  OR'($urandom()), 1'($urandom()), who);
        end

        // ---- reset while CONFIRMED with a pending result
        req_v_i = 4'b1111;
        who = pick(req_v_i, rr);
        nxt();          // START
        nxt();          // SCOUT
        confirm_i = oh(who);
        nxt();          // CONFIRMED
        confirm_i = '0;
        li_v_i    = 1'b1;
        reset_i   = 1'b1;
        settle();
        chk("rstc_no_yumi", li_yumi_o, 0);
        nxt(); settle();
        chk("rstc_grant", grant_o, 0);
        chk("rstc_start", start_discovery_o, 0);
        chk("rstc_conf", confirm_discovery_o, 0);
        chk("rstc_yumi", li_yumi_o, 0);
        chk("rstc_resp_v", resp_v_o, 0);
        chk("rstc_resp_cnt", resp_count_o, 0);
        chk("rstc_pc", striding_pc_o, 0);
        reset_i = 1'b0;
        rr      = 0;
        settle();
        chk("rstc_idle_no_yumi", li_yumi_o, 0);
        li_v_i = 1'b0;

        // ---- round robin with everyone requesting: 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            serve(4'b1111, $urandom_range(0, 3), $urandom_range(0, 2),
                  OR'($urandom()), 1'b0, who);
            chk("rr_order", who, exp_order[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
